// File: rtl/fpu_latency_sequencer.sv
// Latency sequencer for multi-cycle FP ops in the execute stage: decodes the
// function opcode into a latency class, stalls the pipe and pulses done on completion.
module fpu_latency_sequencer #(
    parameter int LAT_C1 = 1,
    parameter int LAT_C2 = 2,
    parameter int LAT_C3 = 3,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid_i,
    input  logic [5:0]       functop_i,
    input  logic [4:0]       issue_rd_i,
    input  logic             flush_i,
    output logic             issue_ready_o,
    output logic             stall_o,
    output logic             done_valid_o,
    output logic [4:0]       done_rd_o,
    output logic             pend_valid_o,
    output logic [4:0]       pend_rd_o,
    output logic [1:0]       lat_class_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [4:0]       pend_rd_q, pend_rd_d;
    logic [1:0]       lat_class_q, lat_class_d;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [1:0]       dec_class;
    logic [3:0]       dec_lat;

    // Opcode to latency class; the classes are disjoint, all else is class 0.
    always_comb begin
        dec_class = 2'd0;
        case (functop_i)
            6'b010011:                                  dec_class = 2'd3;
            6'b010000, 6'b010001, 6'b010010, 6'b010100: dec_class = 2'd2;
            6'b011001, 6'b011010, 6'b010110, 6'b010111: dec_class = 2'd1;
            default:                                    dec_class = 2'd0;
        endcase
        case (dec_class)
            2'd1:    dec_lat = 4'(LAT_C1);
            2'd2:    dec_lat = 4'(LAT_C2);
            2'd3:    dec_lat = 4'(LAT_C3);
            default: dec_lat = 4'd0;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_rd_d     = pend_rd_q;
        lat_class_d   = lat_class_q;
        issue_ready_o = 1'b0;
        stall_o       = 1'b0;
        done_valid_o  = 1'b0;
        done_rd_o     = 5'd0;
        pend_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                issue_ready_o = 1'b1;
                if (issue_valid_i && !flush_i && dec_class != 2'd0) begin
                    stall_o     = 1'b1;
                    state_d     = RUN;
                    cnt_d       = dec_lat - 4'd1;
                    pend_rd_d   = issue_rd_i;
                    lat_class_d = dec_class;
                end
            end
            RUN: begin
                pend_valid_o = 1'b1;
                if (flush_i) begin
                    // Aborted op never reports completion.
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    pend_rd_d   = 5'd0;
                    lat_class_d = 2'd0;
                end else if (cnt_q != 4'd0) begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    done_valid_o = 1'b1;
                    done_rd_o    = pend_rd_q;
                    state_d      = IDLE;
                    pend_rd_d    = 5'd0;
                    lat_class_d  = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            pend_rd_q      <= 5'd0;
            lat_class_q    <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_rd_q   <= pend_rd_d;
            lat_class_q <= lat_class_d;
            if (stall_o) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    assign pend_rd_o      = pend_valid_o ? pend_rd_q : 5'd0;
    assign lat_class_o    = lat_class_q;
    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_fpu_latency_sequencer.sv
// Directed bench for fpu_latency_sequencer: opcode table sweep plus hand-written
// sequences for flush, back-to-back issue, mid-op reset and counter wrap.
module tb_fpu_latency_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  functop;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        issue_ready, stall, done_valid, pend_valid;
    logic [4:0]  done_rd, pend_rd;
    logic [1:0]  lat_class;
    logic [31:0] stall_cycles;
    logic        issue_ready4, stall4, done_valid4, pend_valid4;
    logic [4:0]  done_rd4, pend_rd4;
    logic [1:0]  lat_class4;
    logic [3:0]  stall_cycles4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fpu_latency_sequencer dut (
        .clk(clk), .rst(rst), .issue_valid_i(issue_valid), .functop_i(functop),
        .issue_rd_i(issue_rd), .flush_i(flush), .issue_ready_o(issue_ready),
        .stall_o(stall), .done_valid_o(done_valid), .done_rd_o(done_rd),
        .pend_valid_o(pend_valid), .pend_rd_o(pend_rd), .lat_class_o(lat_class),
        .stall_cycles_o(stall_cycles)
    );

    fpu_latency_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .issue_valid_i(issue_valid), .functop_i(functop),
        .issue_rd_i(issue_rd), .flush_i(flush), .issue_ready_o(issue_ready4),
        .stall_o(stall4), .done_valid_o(done_valid4), .done_rd_o(done_rd4),
        .pend_valid_o(pend_valid4), .pend_rd_o(pend_rd4), .lat_class_o(lat_class4),
        .stall_cycles_o(stall_cycles4)
    );

    typedef struct {
        logic [5:0] op;
        logic [4:0] rd;
        int         lat;
        logic [1:0] cls;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Advance to the next negedge and let combinational outputs settle.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        flush = 1'b0;
        functop = 6'd0;
        issue_rd = 5'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
    endtask

    // Issue one op from IDLE and follow it to completion.
    task automatic run_vec(input vec_t v);
        int cyc;
        int nstall;
        issue_valid = 1'b1;
        functop = v.op;
        issue_rd = v.rd;
        #1;
        check("accept_ready", 32'(issue_ready), 32'd1);
        check("accept_stall", 32'(stall), 32'(v.lat != 0));
        nstall = int'(stall);
        next_cycle();
        issue_valid = 1'b0;
        #1;
        if (v.lat == 0) begin
            check("c0_pend_valid", 32'(pend_valid), 32'd0);
            check("c0_done_valid", 32'(done_valid), 32'd0);
            check("c0_stall", 32'(stall), 32'd0);
        end else begin
            check("run_lat_class", 32'(lat_class), 32'(v.cls));
            check("run_pend_rd", 32'(pend_rd), 32'(v.rd));
            cyc = 1;
            while (!done_valid && cyc < 20) begin
                nstall += int'(stall);
                next_cycle();
                cyc++;
            end
            check("done_seen", 32'(done_valid), 32'd1);
            check("done_cycle", 32'(cyc), 32'(v.lat));
            check("stall_len", 32'(nstall), 32'(v.lat));
            check("done_rd", 32'(done_rd), 32'(v.rd));
            check("done_stall", 32'(stall), 32'd0);
            check("done_ready", 32'(issue_ready), 32'd0);
            next_cycle();
            check("after_pend_valid", 32'(pend_valid), 32'd0);
            check("after_lat_class", 32'(lat_class), 32'd0);
            check("after_ready", 32'(issue_ready), 32'd1);
        end
    endtask

    initial begin
        vec_t vecs[16];
        vec_t fdiv7;
        logic seen_done;

        vecs[0]  = '{6'b010011, 5'd7,  3, 2'd3};  // fdiv
        vecs[1]  = '{6'b010000, 5'd1,  2, 2'd2};
        vecs[2]  = '{6'b010001, 5'd2,  2, 2'd2};
        vecs[3]  = '{6'b010010, 5'd4,  2, 2'd2};
        vecs[4]  = '{6'b010100, 5'd31, 2, 2'd2};
        vecs[5]  = '{6'b011001, 5'd9,  1, 2'd1};
        vecs[6]  = '{6'b011010, 5'd10, 1, 2'd1};
        vecs[7]  = '{6'b010110, 5'd11, 1, 2'd1};
        vecs[8]  = '{6'b010111, 5'd12, 1, 2'd1};
        vecs[9]  = '{6'b010101, 5'd13, 0, 2'd0};  // fneg
        vecs[10] = '{6'b011000, 5'd14, 0, 2'd0};  // feq
        vecs[11] = '{6'b011011, 5'd15, 0, 2'd0};
        vecs[12] = '{6'b011111, 5'd16, 0, 2'd0};
        vecs[13] = '{6'b000000, 5'd17, 0, 2'd0};
        vecs[14] = '{6'b111111, 5'd18, 0, 2'd0};
        vecs[15] = '{6'b110011, 5'd19, 0, 2'd0};
        fdiv7 = vecs[0];

        do_reset();
        check("rst_ready", 32'(issue_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done_valid), 32'd0);
        check("rst_done_rd", 32'(done_rd), 32'd0);
        check("rst_pend_valid", 32'(pend_valid), 32'd0);
        check("rst_pend_rd", 32'(pend_rd), 32'd0);
        check("rst_lat_class", 32'(lat_class), 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);

        // fdiv rd=7 right after reset, then stall counter.
        run_vec(fdiv7);
        check("fdiv_stall_cycles", stall_cycles, 32'd3);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // fneg then feq back-to-back.
        issue_valid = 1'b1; functop = 6'b010101; issue_rd = 5'd5; #1;
        check("fneg_stall", 32'(stall), 32'd0);
        next_cycle();
        functop = 6'b011000; #1;
        check("feq_stall", 32'(stall), 32'd0);
        check("feq_ready", 32'(issue_ready), 32'd1);
        next_cycle();
        issue_valid = 1'b0; #1;
        check("b2b_done", 32'(done_valid), 32'd0);
        check("b2b_pend_valid", 32'(pend_valid), 32'd0);

        // fadd rd=3 flushed in cycle 1.
        issue_valid = 1'b1; functop = 6'b010000; issue_rd = 5'd3; #1;
        check("fadd_c0_stall", 32'(stall), 32'd1);
        next_cycle();
        issue_valid = 1'b0; flush = 1'b1; #1;
        check("flush_c1_stall", 32'(stall), 32'd0);
        check("flush_c1_done", 32'(done_valid), 32'd0);
        check("flush_c1_pend", 32'(pend_valid), 32'd1);
        next_cycle();
        flush = 1'b0; #1;
        check("flush_c2_pend", 32'(pend_valid), 32'd0);
        check("flush_c2_ready", 32'(issue_ready), 32'd1);
        seen_done = done_valid;
        next_cycle(); seen_done |= done_valid;
        next_cycle(); seen_done |= done_valid;
        check("flush_no_done", 32'(seen_done), 32'd0);

        // flush in IDLE ignores the presented op.
        issue_valid = 1'b1; functop = 6'b010011; flush = 1'b1; #1;
        check("idle_flush_stall", 32'(stall), 32'd0);
        next_cycle();
        issue_valid = 1'b0; flush = 1'b0; #1;
        check("idle_flush_pend", 32'(pend_valid), 32'd0);

        // flt rd=9 with fmul rd=4 waiting behind it.
        issue_valid = 1'b1; functop = 6'b011001; issue_rd = 5'd9; #1;
        check("flt_c0_stall", 32'(stall), 32'd1);
        next_cycle();
        functop = 6'b010010; issue_rd = 5'd4; #1;
        check("flt_c1_done", 32'(done_valid), 32'd1);
        check("flt_c1_done_rd", 32'(done_rd), 32'd9);
        check("flt_c1_ready", 32'(issue_ready), 32'd0);
        check("flt_c1_stall", 32'(stall), 32'd0);
        next_cycle();
        check("fmul_c2_ready", 32'(issue_ready), 32'd1);
        check("fmul_c2_stall", 32'(stall), 32'd1);
        next_cycle();
        issue_valid = 1'b0; #1;
        check("fmul_c3_stall", 32'(stall), 32'd1);
        check("fmul_c3_class", 32'(lat_class), 32'd2);
        check("fmul_c3_pend_rd", 32'(pend_rd), 32'd4);
        next_cycle();
        check("fmul_c4_done", 32'(done_valid), 32'd1);
        check("fmul_c4_done_rd", 32'(done_rd), 32'd4);
        next_cycle();

        // Reset in cycle 1 of an fdiv.
        issue_valid = 1'b1; functop = 6'b010011; issue_rd = 5'd7; #1;
        next_cycle();
        issue_valid = 1'b0; rst = 1'b1; #1;
        next_cycle();
        rst = 1'b0; #1;
        check("mrst_ready", 32'(issue_ready), 32'd1);
        check("mrst_stall", 32'(stall), 32'd0);
        check("mrst_pend_valid", 32'(pend_valid), 32'd0);
        check("mrst_stall_cycles", stall_cycles, 32'd0);
        seen_done = done_valid;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            seen_done |= done_valid;
        end
        check("mrst_no_done", 32'(seen_done), 32'd0);

        // Six fdivs: 18 stall cycles wraps a 4-bit counter to 2.
        do_reset();
        for (int i = 0; i < 6; i++) run_vec(fdiv7);
        check("wrap_cnt4", 32'(stall_cycles4), 32'd2);
        check("wrap_cnt32", stall_cycles, 32'd18);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_latency_sequencer.md
Name: fpu_latency_sequencer

Overview:
Sequences multi-cycle floating-point operations through the execute-stage ALU. It decodes the 6-bit function opcode into a latency class and holds a pipeline stall for the required number of cycles. It signals completion with a one-cycle done pulse and exposes the pending destination register for hazard checks. It replaces ad-hoc shift-counter stall logic with an explicit FSM and handles flush and reset cleanly.

Parameters:
LAT_C1, 1, cycles for class-1 ops (flt, fle, fmin, fmax); legal 1..15
LAT_C2, 2, cycles for class-2 ops (fadd, fsub, fmul, fsqrt); legal 1..15
LAT_C3, 3, cycles for class-3 ops (fdiv); legal 1..15
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
issue_valid  input  1  an ALU op is presented this cycle
functop  input  6  ALU function opcode (aluctl[5:0])
issue_rd  input  5  destination register of the presented op
flush  input  1  branch-taken flush; aborts any in-flight op
issue_ready  output  1  sequencer can accept a new op
stall  output  1  active-high pipeline stall (feeds n_stall inversion)
done_valid  output  1  one-cycle pulse: multi-cycle result valid on ALU output
done_rd  output  5  destination of the completing op
pend_valid  output  1  a multi-cycle op is in flight
pend_rd  output  5  destination of the in-flight op
lat_class  output  2  registered class of the in-flight op (0 when idle)
stall_cycles  output  CNT_W  count of cycles with stall=1 since reset

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Class decode is combinational on functop:
  - class3 = 010011
  - class2 = 010000, 010001, 010010, 010100
  - class1 = 011001, 011010, 010110, 010111
  - everything else = class0, including fneg 010101, feq 011000, moves/conversions 011011–011111 and all non-FP opcodes.
  - The classes are mutually exclusive.
- Latency N(class) is 0, LAT_C1, LAT_C2 or LAT_C3.
- FSM states: IDLE, RUN.
- IDLE:
  - issue_ready=1.
  - An accepted op (issue_valid && !flush) of class0 causes no state change, no stall and no done pulse.
  - An accepted op of class>0:
    - Combinationally asserts stall in the accept cycle (cycle 0).
    - Registers cnt = N-1, pend_rd = issue_rd, lat_class = class.
    - Next state is RUN.
- RUN:
  - issue_ready=0.
  - pend_valid=1.
  - While cnt != 0: stall=1, cnt decrements.
  - When cnt == 0 in RUN:
    - stall=0.
    - done_valid=1 and done_rd=pend_rd combinationally in that cycle.
    - Next state is IDLE; lat_class and pend_valid clear next cycle.
- Timing: stall is high for exactly N consecutive cycles (cycles 0..N-1) and done_valid is high in cycle N. Upstream holds functop and operands stable while stall=1; they are sampled only in cycle 0.
- A new op presented in the done cycle is not accepted (issue_ready=0). It is accepted the following cycle.
- flush:
  - In IDLE: the presented op is ignored.
  - In RUN: next state is IDLE, cnt=0, no done pulse is ever produced for the aborted op.
  - stall is forced 0 in any cycle where flush=1.
- rst (any state, including mid-RUN):
  - state=IDLE, cnt=0, pend_rd=0, lat_class=0, stall_cycles=0.
  - All outputs deasserted except issue_ready=1.
- stall_cycles increments when stall=1 and wraps modulo 2^CNT_W.
- Output values while idle: done_rd=0 when done_valid=0; pend_rd reads 0 when pend_valid=0.

Test Plan:
- Reset, then issue fdiv (010011, rd=7) with defaults:
  - stall=1 for cycles 0,1,2.
  - Cycle 3: done_valid=1, done_rd=7, stall=0.
  - Cycle 4: issue_ready=1, pend_valid=0; stall_cycles=3.
- Issue fneg (010101) then feq (011000) back-to-back: stall stays 0, done_valid never asserts, state stays IDLE.
- Issue fadd (010000, rd=3), then assert flush in cycle 1:
  - stall=0 in cycle 1.
  - Cycle 2: IDLE, pend_valid=0.
  - No done_valid in cycles 1–4.
- Issue flt (011001, rd=9) and hold fmul (010010, rd=4) pending:
  - Cycle 0: flt stall=1.
  - Cycle 1: flt done_valid=1, done_rd=9; fmul not accepted.
  - Cycle 2: fmul accepted, stall=1 in cycles 2–3.
  - Cycle 4: done_valid=1, done_rd=4.
- Assert rst in cycle 1 of an fdiv: next cycle issue_ready=1, stall=0, pend_valid=0, stall_cycles=0, and no done pulse.
- CNT_W=4: run 6 fdivs (18 stall cycles) -> stall_cycles=2 (wrap).
